// File: rtl/djpeg_stream_ctrl.sv
// Purpose: fetch one compressed JPEG word stream from memory and feed it to aq_djpeg through a small FIFO, then report completion.
// Latency: first mem_req two cycles after start, first word at the decoder one cycle after its mem_ack; done one cycle after the decoder returns to idle.
// Backpressure: fetches stop while the FIFO is full; dec_data_read low simply holds the FIFO head.

// Small generic FIFO with synchronous flush; a push when full and a pop when empty are ignored.
module djpeg_fifo #(
    parameter int W    = 32,
    parameter int LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << LOG2;

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   count;
    logic            do_wr;
    logic            do_rd;

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full   = count[LOG2];
    assign empty  = (count == '0);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_vld && !empty;
    assign rd_dat = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + LOG2'(1);
            if (do_rd) rd_ptr <= rd_ptr + LOG2'(1);
            if (do_wr && !do_rd)      count <= count + (LOG2+1)'(1);
            else if (!do_wr && do_rd) count <= count - (LOG2+1)'(1);
        end
    end

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module djpeg_stream_ctrl #(
    parameter int ADDR_W    = 24,
    parameter int LEN_W     = 20,
    parameter int FIFO_LOG2 = 2,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_used,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       dec_data,
    output logic              dec_data_en,
    input  logic              dec_data_read,
    input  logic              dec_idle
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  fetched_q;
    logic [TO_W-1:0]   stall_q;
    logic              seen_active_q;
    logic              dec_idle_q;
    logic              mem_req_d;
    logic              timeout_hit;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic              progress;
    logic              finish_ok;
    logic              timed_out;
    logic              fifo_full;
    logic              fifo_empty;

    assign start_ok    = (state_q == IDLE) && start;
    assign busy        = (state_q == STREAM) || (state_q == DRAIN);
    assign done        = (state_q == FINISH);
    // mem_req is only ever high in STREAM, so an ack outside a live request is dropped
    assign push        = mem_req && mem_ack && (state_q == STREAM);
    assign dec_data_en = busy && !fifo_empty;
    assign pop         = dec_data_en && dec_data_read;
    assign progress    = push || pop || (dec_idle != dec_idle_q);
    // the decoder must have been seen working before idle means end-of-image
    assign finish_ok   = seen_active_q && dec_idle;
    assign timed_out   = (stall_q == TO_W'(TIMEOUT - 1)) && !progress;

    djpeg_fifo #(.W(32), .LOG2(FIFO_LOG2)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (done),
        .wr_vld (push),
        .wr_dat (mem_rdata),
        .rd_vld (pop),
        .rd_dat (dec_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state, timeout flag and next request
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        mem_req_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len_words != '0) ? STREAM : FINISH;
            end
            STREAM: begin
                if (finish_ok) begin
                    state_d = FINISH;
                end else if (timed_out) begin
                    state_d     = FINISH;
                    timeout_hit = 1'b1;
                end else if ((fetched_q == len_q) && !mem_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (finish_ok) begin
                    state_d = FINISH;
                end else if (timed_out) begin
                    state_d     = FINISH;
                    timeout_hit = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // one outstanding request; a new one only starts the cycle after an ack
        if ((state_q == STREAM) && (state_d == STREAM)) begin
            if (mem_req) mem_req_d = !mem_ack;
            else         mem_req_d = (fetched_q < len_q) && !fifo_full;
        end
    end

    // datapath: address, counters, status and stall watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            len_q         <= '0;
            fetched_q     <= '0;
            words_used    <= '0;
            error         <= 1'b0;
            seen_active_q <= 1'b0;
            dec_idle_q    <= 1'b1;
            stall_q       <= '0;
        end else begin
            mem_req    <= mem_req_d;
            dec_idle_q <= dec_idle;
            if (start_ok) begin
                mem_addr      <= base_addr;
                len_q         <= len_words;
                fetched_q     <= '0;
                words_used    <= '0;
                error         <= (len_words == '0);
                seen_active_q <= 1'b0;
                stall_q       <= '0;
            end else begin
                if (push) begin
                    mem_addr  <= mem_addr + ADDR_W'(1);
                    fetched_q <= fetched_q + LEN_W'(1);
                end
                if (pop)                words_used    <= words_used + LEN_W'(1);
                if (busy && !dec_idle)  seen_active_q <= 1'b1;
                if (timeout_hit)        error         <= 1'b1;
                if (!busy || progress)  stall_q       <= '0;
                else                    stall_q       <= stall_q + TO_W'(1);
            end
        end
    end
endmodule

// File: doc/djpeg_stream_ctrl.md
Name: djpeg_stream_ctrl

Overview:
- Sequences one JPEG decode on the aq_djpeg core.
- On a start command it fetches a compressed word stream from word-addressed memory through a req/ack read port. It buffers the words in a small FIFO and presents them on the decoder's DataIn/DataInEnable/DataInRead handshake.
- It watches JpegDecodeIdle to decide when the decode is complete.
- It sits between the photoframe's image-select logic / memory port and aq_djpeg.

Parameters:
- ADDR_W, 24, memory word-address width
- LEN_W, 20, width of the word-count field
- FIFO_LOG2, 2, log2 of FIFO depth (default depth 4 words)
- TIMEOUT, 1000000, stall limit in cycles with no progress before an error is flagged

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on an accepted start
- len_words  in  LEN_W  stream length in 32-bit words, latched on an accepted start
- busy  out  1  high from an accepted start until the cycle done is asserted
- done  out  1  one-cycle completion pulse
- error  out  1  status valid with done: zero length or timeout; held until the next accepted start
- words_used  out  LEN_W  words consumed by the decoder; held until the next accepted start
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address; stable while mem_req is high
- mem_ack  in  1  request accepted; mem_rdata is valid in the same cycle
- mem_rdata  in  32  read data
- dec_data  out  32  to DataIn; equals the FIFO head
- dec_data_en  out  1  to DataInEnable
- dec_data_read  in  1  from DataInRead; pops the head when dec_data_en is high
- dec_idle  in  1  from JpegDecodeIdle

Behaviour:
- Reset values: busy=0, done=0, error=0, words_used=0, mem_req=0, mem_addr=0, dec_data_en=0; FIFO empty; state IDLE. dec_data is don't-care while dec_data_en=0.
- A reset in any state (including with mem_req pending) returns to IDLE next cycle and flushes the FIFO. An in-flight ack is ignored.
- States: IDLE, STREAM, DRAIN, FINISH.
- IDLE transitions:
  - On start with len_words!=0: latch inputs, clear words_used and error, set busy, go to STREAM next cycle.
  - On start with len_words==0: go to FINISH with error=1; busy is never asserted.
- STREAM, memory side:
  - At most one outstanding request.
  - Assert mem_req when fetched < len and (fifo_count + 1) <= depth.
  - Hold mem_req and mem_addr until mem_ack. On mem_ack: push mem_rdata, increment mem_addr and fetched. mem_req may reassert in the following cycle (one request per 2 cycles minimum).
- STREAM, decoder side:
  - dec_data_en = (fifo_count != 0).
  - A pop occurs when dec_data_en && dec_data_read; each pop increments words_used.
  - Push and pop in the same cycle leave fifo_count unchanged. A full FIFO never receives a push; an empty FIFO never pops.
- STREAM to DRAIN: when fetched == len and no request is outstanding.
- DRAIN: keeps serving FIFO words; issues no new requests. dec_data_en falls when the FIFO empties. Excess words left when the decoder finishes are discarded at FINISH.
- seen_active flag: cleared on an accepted start; set on any cycle with dec_idle=0 while busy.
- Completion: in STREAM or DRAIN, when seen_active && dec_idle, go to FINISH. Remaining FIFO words and any pending request are abandoned (mem_req drops; any ack arriving after that is ignored).
- Timeout: a stall counter resets on any push, pop, or dec_idle transition. When it reaches TIMEOUT-1 in STREAM or DRAIN, set error=1 and go to FINISH.
- FINISH: asserts done for exactly one cycle, clears busy in that same cycle, flushes the FIFO, then returns to IDLE.
- start while busy is ignored.
- All counters are unsigned and wrap-free: fetched and words_used never exceed len.

Test Plan:
- Normal decode: base=0x100, len=8; memory returns 0xA0..A7; the decoder model pops whenever dec_data_en, drops dec_idle after the 2nd word, raises it after the 8th. Required: dec_data sequence A0..A7 in order; mem_addr 0x100..0x107; done one cycle; error=0; words_used=8; busy low the same cycle as done.
- Backpressure: dec_data_read held 0 for 20 cycles. Required: exactly 4 mem_acks, then mem_req=0 with FIFO full; no data lost once reads resume; order preserved.
- Early EOI: len=16; decoder goes idle after 5 pops. Required: done within 2 cycles of dec_idle rising, words_used=5, mem_req=0 afterwards, FIFO empty.
- Zero length / timeout: len=0 gives done with error=1 one cycle after start and no mem_req. With TIMEOUT=50 and mem_ack never asserted, done with error=1 occurs 50 cycles after the last progress.
- Reset mid-stream: rst pulsed while mem_req=1 and the FIFO holds 2 words. Required: all outputs at reset values next cycle; a late mem_ack causes no push. A following start/len=4 completes normally.
